fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Fetch-stage controller that owns the word-addressed program counter and sequences it against a single-outstanding instruction-memory handshake. It presents fetched instructions to decode over a valid/ready interface. It accepts branch/jump and trap redirects with fixed priority, flushing wrong-path fetches, and supports a halt state. It sits between imem and decode, and replaces direct free-running PC increment.

Parameters:
RESET_PC, 32'h0, PC value loaded on reset (word address).
XLEN, 32, address/instruction width.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  XLEN  fetch word address, stable while imem_req=1
imem_ack  in  1  fetch complete, imem_rdata valid this cycle
imem_rdata  in  XLEN  fetched instruction
inst_valid  out  1  instruction available to decode
inst  out  XLEN  held instruction
inst_pc  out  XLEN  address of held instruction
inst_ready  in  1  decode accepts inst
br_valid  in  1  branch/jump redirect request (1-cycle pulse)
br_target  in  XLEN  branch/jump target
trap_valid  in  1  trap redirect request (1-cycle pulse)
trap_vector  in  XLEN  trap handler address
halt  in  1  level; stop fetching after current instruction is accepted
halted  out  1  sequencer in HALT

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: state=BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, halted=0, redirect-pending flag=0.
- Reset mid-fetch: the outstanding ack is not tracked. Any imem_ack arriving while in BOOT is ignored.
- Redirect: trap_valid wins over br_valid when both are asserted. The selected target is the redirect for that cycle.
- imem_addr always equals pc.
- PC arithmetic: pc+1 modulo 2^XLEN; 32'hFFFFFFFF wraps to 0.
- States:
  - BOOT: all outputs idle. Next cycle goes to FETCH. A redirect in BOOT loads pc=target, then goes to FETCH.
  - FETCH: imem_req=1.
    - Ack with no pending redirect and no redirect this cycle: inst<=rdata, inst_pc<=pc, pc<=pc+1, go to HOLD. inst_valid rises the cycle after ack.
    - Redirect without ack: the address must stay stable. Latch the target into pending, set the pending flag, hold pc.
    - Ack with the pending flag set, or with a redirect this cycle: discard rdata. pc<=current-cycle target if present, else the pending target. Clear the pending flag. Stay in FETCH; the new address is issued next cycle.
    - Ack in the same cycle as the request (zero-wait memory) is legal.
  - HOLD: inst_valid=1, imem_req=0; inst and inst_pc are stable.
    - Redirect (with or without inst_ready): pc<=target, inst_valid=0 next cycle, go to FETCH.
    - Else inst_ready=1 with halt=1: go to HALT.
    - Else inst_ready=1: go to FETCH; imem_req rises next cycle.
    - Else: stay in HOLD.
  - HALT: halted=1, imem_req=0, inst_valid=0. A redirect loads pc=target, clears halted next cycle, and goes to FETCH. Deasserting halt alone does not exit HALT.
- Throughput: at most one instruction per 2 cycles. No prefetch.

Optional Feature:
FETCH_PERF_CNT_EN: when defined, two extra outputs are present:
- perf_fetched (32): increments on each HOLD accept (inst_valid and inst_ready with no redirect).
- perf_flushed (32): increments on each discarded ack and on each HOLD instruction dropped by a redirect.
- Both reset to 0 and wrap at 2^32.

When not defined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- fetch_pkg: state encoding localparams (BOOT, FETCH, HOLD, HALT), default RESET_PC, XLEN.
- One sub-module, fetch_redirect_arb: combinational trap>branch priority select plus the pending-target/pending-flag register. Outputs redir_now, redir_target and the effective pending target.
- The FSM and PC live in fetch_sequencer.

Test Plan:
- Reset with RESET_PC=0x100, zero-wait imem, inst_ready=1 -> imem_addr sequence 0x100,0x101,0x102; inst_pc matches; inst_valid every other cycle.
- imem_ack delayed 3 cycles, br_valid target 0x40 in the 2nd wait cycle -> imem_addr stays at the old value until ack; rdata discarded (no inst_valid); next imem_addr=0x40.
- trap_valid (vector 0x8) and br_valid (0x20) in the same cycle during HOLD -> inst_valid drops next cycle; next fetch at 0x8.
- HOLD with inst_ready=0 for 5 cycles -> inst and inst_pc stable, imem_req=0; ready asserted -> fetch of pc+1 next cycle.
- halt=1 at accept of pc 0x10 -> halted=1, no imem_req; br_valid target 0x200 -> fetch at 0x200, halted=0.
- pc=0xFFFFFFFF accepted -> next imem_addr=0x0. With FETCH_PERF_CNT_EN, perf_fetched and perf_flushed match counts from the scenarios above.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch sequencer and its redirect arbiter.
// No logic; types and constants only.
// Not applicable.
package fetch_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;

  // Sequencer states: BOOT after reset, FETCH while a request is outstanding,
  // HOLD while decode owns the instruction, HALT until a redirect arrives.
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_arb.sv
// Redirect arbiter: trap beats branch, and remembers a redirect that arrived mid-fetch.
// Select is combinational (0 cycles); the pending target is visible the cycle after pend_set.
// No backpressure: redirects are single-cycle pulses and the newest pending target wins.
module fetch_redirect_arb
  import fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            pend_set,
  input  logic            pend_clr,
  output logic            redir_now,
  output logic [XLEN-1:0] redir_target,
  output logic            pend_valid,
  output logic [XLEN-1:0] pend_target
);

  logic            pend_vld_q, pend_vld_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;

  // Fixed priority: a trap always overrides a branch in the same cycle.
  always_comb begin
    redir_now    = trap_valid | br_valid;
    redir_target = trap_valid ? trap_vector : br_target;
  end

  // Pending slot: set captures this cycle's winner, clear drops it once consumed.
  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    if (pend_set) begin
      pend_vld_d = 1'b1;
      pend_tgt_d = redir_target;
    end else if (pend_clr) begin
      pend_vld_d = 1'b0;
    end
  end

  // Pending redirect registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pend_valid  = pend_vld_q;
  assign pend_target = pend_tgt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC sequencer with one outstanding imem request; optional counters via FETCH_PERF_CNT_EN.
// inst_valid rises the cycle after imem_ack; at most one instruction every 2 cycles.
// Holds the instruction in HOLD until inst_ready; imem_req is held until imem_ack.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int            XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF[XLEN-1:0]
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            halt,
  output logic            halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;

  logic            redir_now;
  logic [XLEN-1:0] redir_target;
  logic            pend_valid;
  logic [XLEN-1:0] pend_target;
  logic            pend_set;
  logic            pend_clr;

  fetch_redirect_arb #(
    .XLEN(XLEN)
  ) u_arb (
    .clk          (clk),
    .reset_n      (reset_n),
    .br_valid     (br_valid),
    .br_target    (br_target),
    .trap_valid   (trap_valid),
    .trap_vector  (trap_vector),
    .pend_set     (pend_set),
    .pend_clr     (pend_clr),
    .redir_now    (redir_now),
    .redir_target (redir_target),
    .pend_valid   (pend_valid),
    .pend_target  (pend_target)
  );

  // Next state, PC and held instruction; a redirect arriving mid-fetch is parked
  // so imem_addr stays stable until the outstanding ack returns.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    case (state_q)
      ST_BOOT: begin
        // Acks here belong to a fetch cut off by reset and are ignored.
        if (redir_now) pc_d = redir_target;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          if (redir_now || pend_valid) begin
            // Wrong-path data: drop it and reissue at the redirect target.
            pc_d     = redir_now ? redir_target : pend_target;
            pend_clr = 1'b1;
          end else begin
            inst_d    = imem_rdata;
            inst_pc_d = pc_q;
            pc_d      = pc_q + {{(XLEN-1){1'b0}}, 1'b1};
            state_d   = ST_HOLD;
          end
        end else if (redir_now) begin
          pend_set = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redir_now) begin
          pc_d    = redir_target;
          state_d = ST_FETCH;
        end else if (inst_ready) begin
          state_d = halt ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: begin
        if (redir_now) begin
          pc_d    = redir_target;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // Sequencer state, PC and held instruction registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  assign imem_req   = (state_q == ST_FETCH);
  assign imem_addr  = pc_q;
  assign inst_valid = (state_q == ST_HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign halted     = (state_q == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic        acc_evt;
  logic        flush_evt;
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] flushed_q, flushed_d;

  // Accepted instructions and wrong-path drops (discarded acks plus held instructions killed by a redirect).
  always_comb begin
    acc_evt   = (state_q == ST_HOLD) && inst_ready && !redir_now;
    flush_evt = ((state_q == ST_FETCH) && imem_ack && (redir_now || pend_valid)) ||
                ((state_q == ST_HOLD) && redir_now);
    fetched_d = fetched_q + {31'd0, acc_evt};
    flushed_d = flushed_q + {31'd0, flush_evt};
  end

  // Free-running wrap-around counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      flushed_q <= flushed_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
`else
  // Counters are not built; the sequencer behaves identically without them.
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle vector table plus a reset-mid-fetch sequence.
// Outputs are sampled 2 time units after the rising edge, inputs driven 1 unit after.
// Memory and decode are modelled directly by the table inputs.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        br_valid;
  logic [31:0] br_target;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        halt;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .XLEN     (32),
    .RESET_PC (32'h100)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .trap_valid  (trap_valid),
    .trap_vector (trap_vector),
    .halt        (halt),
    .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_flushed(perf_flushed)
`endif
  );

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        br;
    logic [31:0] brt;
    logic        tr;
    logic [31:0] trv;
    logic        hlt_in;
    logic        req;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ipc;
    logic [31:0] ins;
    logic        hlt;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic ack, input logic [31:0] rdata, input logic rdy,
                              input logic br, input logic [31:0] brt,
                              input logic tr, input logic [31:0] trv, input logic hlt_in,
                              input logic req, input logic [31:0] addr, input logic iv,
                              input logic [31:0] ipc, input logic [31:0] ins, input logic hlt);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.rdy = rdy; v.br = br; v.brt = brt;
    v.tr = tr; v.trv = trv; v.hlt_in = hlt_in;
    v.req = req; v.addr = addr; v.iv = iv; v.ipc = ipc; v.ins = ins; v.hlt = hlt;
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic req, input logic [31:0] addr,
                          input logic iv, input logic [31:0] ipc, input logic [31:0] ins,
                          input logic hlt);
    chk({tag, " imem_req"},   {31'd0, imem_req},   {31'd0, req});
    chk({tag, " imem_addr"},  imem_addr,           addr);
    chk({tag, " inst_valid"}, {31'd0, inst_valid}, {31'd0, iv});
    chk({tag, " inst_pc"},    inst_pc,             ipc);
    chk({tag, " inst"},       inst,                ins);
    chk({tag, " halted"},     {31'd0, halted},     {31'd0, hlt});
  endtask

  task automatic drive_idle();
    imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    br_valid = 1'b0; br_target = '0; trap_valid = 1'b0; trap_vector = '0; halt = 1'b0;
  endtask

  initial begin
    // Zero-wait fetches with decode always ready.
    add(0, 32'h0,    1, 0, 32'h0, 0, 32'h0, 0,  0, 32'h100, 0, 32'h0,   32'h0,    0); // c0 BOOT
    add(1, 32'hA100, 1, 0, 32'h0, 0, 32'h0, 0,  1, 32'h100, 0, 32'h0,   32'h0,    0);
    add(0, 32'h0,    1, 0, 32'h0, 0, 32'h0, 0,  0, 32'h101, 1, 32'h100, 32'hA100, 0);
    add(1, 32'hA101, 1, 0, 32'h0, 0, 32'h0, 0,  1, 32'h101, 0, 32'h100, 32'hA100, 0);
    add(0, 32'h0,    1, 0, 32'h0, 0, 32'h0, 0,  0, 32'h102, 1, 32'h101, 32'hA101, 0);
    add(1, 32'hA102, 1, 0, 32'h0, 0, 32'h0, 0,  1, 32'h102, 0, 32'h101, 32'hA101, 0);
    add(0, 32'h0,    1, 0, 32'h0, 0, 32'h0, 0,  0, 32'h103, 1, 32'h102, 32'hA102, 0); // c6
    // Slow ack with a branch in the second wait cycle: address held, data dropped.
    add(0, 32'h0,    0, 0, 32'h0,  0, 32'h0, 0, 1, 32'h103, 0, 32'h102, 32'hA102, 0);
    add(0, 32'h0,    0, 1, 32'h40, 0, 32'h0, 0, 1, 32'h103, 0, 32'h102, 32'hA102, 0);
    add(0, 32'h0,    0, 0, 32'h0,  0, 32'h0, 0, 1, 32'h103, 0, 32'h102, 32'hA102, 0);
    add(1, 32'hDEAD, 0, 0, 32'h0,  0, 32'h0, 0, 1, 32'h103, 0, 32'h102, 32'hA102, 0); // c10
    add(1, 32'hA040, 0, 0, 32'h0,  0, 32'h0, 0, 1, 32'h40,  0, 32'h102, 32'hA102, 0);
    // Trap and branch together in HOLD: trap vector wins, instruction dropped.
    add(0, 32'h0,    1, 1, 32'h20, 1, 32'h8, 0, 0, 32'h41,  1, 32'h40,  32'hA040, 0); // c12
    add(0, 32'h0,    0, 0, 32'h0,  0, 32'h0, 0, 1, 32'h8,   0, 32'h40,  32'hA040, 0);
    add(1, 32'hA008, 0, 0, 32'h0,  0, 32'h0, 0, 1, 32'h8,   0, 32'h40,  32'hA040, 0);
    // Decode stalls five cycles, then accepts.
    for (int i = 0; i < 5; i++)
      add(0, 32'h0,  0, 0, 32'h0,  0, 32'h0, 0, 0, 32'h9,   1, 32'h8,   32'hA008, 0);
    add(0, 32'h0,    1, 0, 32'h0,  0, 32'h0, 0, 0, 32'h9,   1, 32'h8,   32'hA008, 0); // c20
    add(1, 32'hA009, 0, 0, 32'h0,  0, 32'h0, 0, 1, 32'h9,   0, 32'h8,   32'hA008, 0);
    // Branch to 0x10, then halt on its accept; halt release alone stays halted.
    add(0, 32'h0,    0, 1, 32'h10, 0, 32'h0, 0, 0, 32'hA,   1, 32'h9,   32'hA009, 0); // c22
    add(1, 32'hA010, 0, 0, 32'h0,  0, 32'h0, 0, 1, 32'h10,  0, 32'h9,   32'hA009, 0);
    add(0, 32'h0,    1, 0, 32'h0,  0, 32'h0, 1, 0, 32'h11,  1, 32'h10,  32'hA010, 0);
    add(0, 32'h0,    0, 0, 32'h0,  0, 32'h0, 0, 0, 32'h11,  0, 32'h10,  32'hA010, 1);
    add(0, 32'h0,    0, 1, 32'h200,0, 32'h0, 0, 0, 32'h11,  0, 32'h10,  32'hA010, 1);
    add(1, 32'hA200, 0, 0, 32'h0,  0, 32'h0, 0, 1, 32'h200, 0, 32'h10,  32'hA010, 0); // c27
    // Branch to the last word; the following address wraps to zero.
    add(0, 32'h0,    0, 1, 32'hFFFFFFFF, 0, 32'h0, 0, 0, 32'h201, 1, 32'h200, 32'hA200, 0);
    add(1, 32'hBEEF, 0, 0, 32'h0,  0, 32'h0, 0, 1, 32'hFFFFFFFF, 0, 32'h200, 32'hA200, 0);
    add(0, 32'h0,    1, 0, 32'h0,  0, 32'h0, 0, 0, 32'h0,   1, 32'hFFFFFFFF, 32'hBEEF, 0); // c30
    // Ack with a same-cycle branch is dropped.
    add(1, 32'hDEAD, 0, 1, 32'h50, 0, 32'h0,  0, 1, 32'h0,  0, 32'hFFFFFFFF, 32'hBEEF, 0);
    // Trap beats branch while parked; the parked trap vector is used at ack.
    add(0, 32'h0,    0, 1, 32'h70, 1, 32'h60, 0, 1, 32'h50, 0, 32'hFFFFFFFF, 32'hBEEF, 0);
    add(1, 32'hDEAD, 0, 0, 32'h0,  0, 32'h0,  0, 1, 32'h50, 0, 32'hFFFFFFFF, 32'hBEEF, 0);
    // A same-cycle redirect at ack overrides the parked one.
    add(0, 32'h0,    0, 1, 32'h90, 0, 32'h0,  0, 1, 32'h60, 0, 32'hFFFFFFFF, 32'hBEEF, 0);
    add(1, 32'hDEAD, 0, 1, 32'h80, 0, 32'h0,  0, 1, 32'h60, 0, 32'hFFFFFFFF, 32'hBEEF, 0);
    add(1, 32'hA080, 0, 0, 32'h0,  0, 32'h0,  0, 1, 32'h80, 0, 32'hFFFFFFFF, 32'hBEEF, 0);
    add(0, 32'h0,    0, 0, 32'h0,  0, 32'h0,  0, 0, 32'h81, 1, 32'h80, 32'hA080, 0);   // c37

    drive_idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk_outs("reset", 1'b0, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      imem_ack = vq[i].ack;   imem_rdata = vq[i].rdata; inst_ready = vq[i].rdy;
      br_valid = vq[i].br;    br_target = vq[i].brt;
      trap_valid = vq[i].tr;  trap_vector = vq[i].trv;  halt = vq[i].hlt_in;
      #1;
      chk_outs($sformatf("vec%0d", i), vq[i].req, vq[i].addr, vq[i].iv, vq[i].ipc,
               vq[i].ins, vq[i].hlt);
    end

`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, 32'd6);
    chk("perf_flushed", perf_flushed, 32'd7);
`endif

    // Reset while an ack is pending; the late ack in BOOT must be ignored,
    // while a branch in BOOT still steers the first fetch.
    @(posedge clk);
    #1;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD;
    reset_n = 1'b0;
    #1;
    chk_outs("midreset", 1'b0, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1; br_valid = 1'b1; br_target = 32'h300;
    #1;
    chk_outs("boot", 1'b0, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    br_valid = 1'b0; imem_ack = 1'b0;
    #1;
    chk_outs("boot_redir", 1'b1, 32'h300, 1'b0, 32'h0, 32'h0, 1'b0);
    imem_ack = 1'b1; imem_rdata = 32'hA300;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    #1;
    chk_outs("boot_fetch", 1'b0, 32'h301, 1'b1, 32'h300, 32'hA300, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
